mux2_stream_arb: RTL and testbench

- Two-to-one stream merger, the inverse of the two-way data demultiplexer.
- Accepts W-bit words on two valid/ready input channels and forwards them on one registered output channel.
- Tags every output word with out_select, the index of its source channel, so a downstream demux can route it back unchanged.
- Round-robin arbitration; sustains one word per clock.

---
 rtl/mux2_stream_arb.sv | 91 +++++++++
 tb/tb_mux2_stream_arb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux2_stream_arb.sv
// rtl/mux2_stream_arb.sv - two-to-one round-robin stream merger with source tag and per-channel counters
module mux2_stream_arb #(
    parameter int W  = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  in_data_0,
    input  logic          in_valid_0,
    output logic          in_ready_0,
    input  logic [W-1:0]  in_data_1,
    input  logic          in_valid_1,
    output logic          in_ready_1,
    output logic [W-1:0]  out_data,
    output logic          out_select,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] count_0,
    output logic [CW-1:0] count_1
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  data_q, data_d;
    logic          sel_q, sel_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt0_q, cnt0_d;
    logic [CW-1:0] cnt1_q, cnt1_d;

    logic can_load;
    logic grant_0;
    logic grant_1;

    // Grants look only at the valids and the pointer, never at data.
    assign can_load   = (state_q == EMPTY) | out_ready;
    assign grant_0    = in_valid_0 & (~in_valid_1 | last_q);
    assign grant_1    = in_valid_1 & (~in_valid_0 | ~last_q);
    assign in_ready_0 = can_load & grant_0;
    assign in_ready_1 = can_load & grant_1;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        if (in_ready_0 && in_valid_0) begin
            state_d = FULL;
            data_d  = in_data_0;
            sel_d   = 1'b0;
            last_d  = 1'b0;
            cnt0_d  = cnt0_q + 1'b1;
        end else if (in_ready_1 && in_valid_1) begin
            state_d = FULL;
            data_d  = in_data_1;
            sel_d   = 1'b1;
            last_d  = 1'b1;
            cnt1_d  = cnt1_q + 1'b1;
        end else if (state_q == FULL && out_ready) begin
            // Drain with no refill: the word stays visible but is no longer valid.
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign out_valid  = (state_q == FULL);
    assign out_data   = data_q;
    assign out_select = sel_q;
    assign count_0    = cnt0_q;
    assign count_1    = cnt1_q;

endmodule

// File: tb/tb_mux2_stream_arb.sv
// tb/tb_mux2_stream_arb.sv - scoreboard bench for mux2_stream_arb
module tb_mux2_stream_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data_0, in_data_1;
    logic        in_valid_0, in_valid_1;
    logic        in_ready_0, in_ready_1;
    logic [15:0] out_data;
    logic        out_select;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  count_0, count_1;

    int total = 0;
    int bad   = 0;

    logic [16:0] sb[$];
    logic [16:0] exp_w;
    logic        m_valid, m_last, m_rdy0, m_rdy1, m_loaded;
    logic [7:0]  m_cnt0, m_cnt1;

    mux2_stream_arb #(.W(16), .CW(8)) dut (
        .clk(clk), .rst(rst),
        .in_data_0(in_data_0), .in_valid_0(in_valid_0), .in_ready_0(in_ready_0),
        .in_data_1(in_data_1), .in_valid_1(in_valid_1), .in_ready_1(in_ready_1),
        .out_data(out_data), .out_select(out_select), .out_valid(out_valid),
        .out_ready(out_ready), .count_0(count_0), .count_1(count_1)
    );

    always #5 clk = ~clk;

    task automatic predict();
        logic can;
        can    = !m_valid || out_ready;
        m_rdy0 = can && in_valid_0 && (!in_valid_1 || m_last);
        m_rdy1 = can && in_valid_1 && (!in_valid_0 || !m_last);
    endtask

    task automatic tick();
        predict();
        m_loaded = 1'b0;
        if (m_rdy0) begin
            sb.push_back({1'b0, in_data_0});
            m_last = 1'b0; m_cnt0 = m_cnt0 + 8'd1; m_valid = 1'b1; m_loaded = 1'b1;
        end else if (m_rdy1) begin
            sb.push_back({1'b1, in_data_1});
            m_last = 1'b1; m_cnt1 = m_cnt1 + 8'd1; m_valid = 1'b1; m_loaded = 1'b1;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_last = 1'b1; m_cnt0 = 8'd0; m_cnt1 = 8'd0;
        sb.delete();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        in_data_0  = 16'($urandom);
        in_data_1  = 16'($urandom);
        in_valid_0 = 1'($urandom);
        in_valid_1 = 1'($urandom);
        out_ready  = 1'($urandom);
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h exp=0000", out_data); end
        total++; if (count_0 !== 8'd0 || count_1 !== 8'd0) begin bad++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", count_0, count_1); end
        rst = 1'b0;
        in_valid_0 = 1'b1; in_data_0 = 16'hAAFF; in_valid_1 = 1'b0; out_ready = 1'b1;
        #1;
        total++; if (in_ready_0 !== 1'b1) begin bad++; $display("FAIL first_ready got=%b exp=1", in_ready_0); end
        tick();
        in_valid_0 = 1'b0;
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL first_word got=none exp=word"); end
        else begin
            exp_w = sb.pop_front();
            if ({out_select, out_data} !== exp_w || out_valid !== 1'b1 || exp_w !== {1'b0, 16'hAAFF})
                begin bad++; $display("FAIL first_word got=%b/%h v=%b exp=0/aaff v=1", out_select, out_data, out_valid); end
        end
        total++; if (count_0 !== 8'd1) begin bad++; $display("FAIL first_count got=%0d exp=1", count_0); end
    endtask

    task automatic test_single1();
        in_valid_0 = 1'b0; in_valid_1 = 1'b1; in_data_1 = 16'hFF8F; out_ready = 1'b1;
        #1;
        predict();
        total++; if (in_ready_1 !== m_rdy1 || in_ready_0 !== 1'b0) begin bad++; $display("FAIL single1_ready got=%b%b exp=%b0", in_ready_1, in_ready_0, m_rdy1); end
        tick();
        in_valid_1 = 1'b0;
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL single1_word got=none exp=word"); end
        else begin
            exp_w = sb.pop_front();
            if ({out_select, out_data} !== exp_w || exp_w !== {1'b1, 16'hFF8F})
                begin bad++; $display("FAIL single1_word got=%b/%h exp=%b/%h", out_select, out_data, exp_w[16], exp_w[15:0]); end
        end
        total++; if (count_1 !== 8'd1) begin bad++; $display("FAIL single1_count got=%0d exp=1", count_1); end
    endtask

    task automatic test_drain();
        in_valid_0 = 1'b0; in_valid_1 = 1'b0; out_ready = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0 || out_data !== 16'hFF8F || out_select !== 1'b1)
            begin bad++; $display("FAIL drain got=v%b %b/%h exp=v0 1/ff8f", out_valid, out_select, out_data); end
    endtask

    task automatic test_contention();
        logic exp_sel;
        do_reset();
        rst = 1'b0;
        in_valid_0 = 1'b1; in_data_0 = 16'hAAFF;
        in_valid_1 = 1'b1; in_data_1 = 16'hFF8F; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_sel = 1'(i % 2);
            total++;
            if (sb.size() == 0) begin bad++; $display("FAIL contend_word[%0d] got=none exp=word", i); end
            else begin
                exp_w = sb.pop_front();
                if ({out_select, out_data} !== exp_w || out_select !== exp_sel || out_valid !== 1'b1)
                    begin bad++; $display("FAIL contend_word[%0d] got=%b/%h v=%b exp=%b v=1", i, out_select, out_data, out_valid, exp_sel); end
            end
        end
        total++; if (count_0 !== 8'd3 || count_1 !== 8'd3) begin bad++; $display("FAIL contend_counts got=%0d/%0d exp=3/3", count_0, count_1); end
    endtask

    task automatic test_backpressure();
        do_reset();
        rst = 1'b0;
        in_valid_0 = 1'b1; in_data_0 = 16'hAAFF; in_valid_1 = 1'b0; out_ready = 1'b1;
        tick();
        if (sb.size() != 0) exp_w = sb.pop_front();
        in_valid_1 = 1'b1; in_data_1 = 16'hFF8F; in_data_0 = 16'h1234; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (in_ready_0 !== 1'b0 || in_ready_1 !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d] got=%b%b exp=00", i, in_ready_0, in_ready_1); end
            tick();
            total++; if (out_data !== 16'hAAFF || out_valid !== 1'b1) begin bad++; $display("FAIL stall_data[%0d] got=%h v=%b exp=aaff v=1", i, out_data, out_valid); end
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready_1 !== 1'b1 || in_ready_0 !== 1'b0) begin bad++; $display("FAIL release_ready got=%b%b exp=10", in_ready_1, in_ready_0); end
        tick();
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL release_word got=none exp=word"); end
        else begin
            exp_w = sb.pop_front();
            if ({out_select, out_data} !== exp_w || exp_w !== {1'b1, 16'hFF8F} || out_valid !== 1'b1)
                begin bad++; $display("FAIL release_word got=%b/%h v=%b exp=1/ff8f v=1", out_select, out_data, out_valid); end
        end
    endtask

    task automatic test_wrap();
        int errs;
        errs = 0;
        do_reset();
        rst = 1'b0;
        in_valid_0 = 1'b1; in_valid_1 = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_data_0 = 16'($urandom);
            tick();
            if (sb.size() == 0) errs++;
            else begin
                exp_w = sb.pop_front();
                if ({out_select, out_data} !== exp_w) errs++;
            end
        end
        in_valid_0 = 1'b0;
        total++; if (errs != 0) begin bad++; $display("FAIL wrap_stream got=%0d bad words exp=0", errs); end
        total++; if (count_0 !== 8'd0 || count_0 !== m_cnt0) begin bad++; $display("FAIL wrap_count0 got=%0d exp=0", count_0); end
        total++; if (count_1 !== 8'd0) begin bad++; $display("FAIL wrap_count1 got=%0d exp=0", count_1); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        rst = 1'b0;
        in_valid_0 = 1'b1; in_data_0 = 16'hAAFF; in_valid_1 = 1'b0; out_ready = 1'b1;
        tick();
        in_valid_0 = 1'b0; in_valid_1 = 1'b1; in_data_1 = 16'hFF8F;
        tick();
        in_valid_1 = 1'b0; out_ready = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 16'hFF8F || count_0 !== 8'd1 || count_1 !== 8'd1)
            begin bad++; $display("FAIL premid got=v%b %h %0d/%0d exp=v1 ff8f 1/1", out_valid, out_data, count_0, count_1); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
        total++; if (count_0 !== 8'd0 || count_1 !== 8'd0) begin bad++; $display("FAIL midrst_counts got=%0d/%0d exp=0/0", count_0, count_1); end
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_data_0 = '0; in_data_1 = '0; in_valid_0 = 1'b0; in_valid_1 = 1'b0; out_ready = 1'b0;
        model_reset();
        m_rdy0 = 1'b0; m_rdy1 = 1'b0; m_loaded = 1'b0; exp_w = '0;
        test_reset();
        test_single1();
        test_drain();
        test_contention();
        test_backpressure();
        test_wrap();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
